// File: rtl/vram_fill_arbiter_if.sv
// Command and write-port bundle between MiniAlu decode, the fill arbiter and video memory.
// master: the instruction-decode side; slave: the arbiter.
interface vram_fill_arbiter_if #(
    parameter int DATA_WIDTH = 3,
    parameter int GRID_BITS  = 5,
    parameter int ADDR_WIDTH = 2 * GRID_BITS
);
    logic                    iCpuWrite;
    logic [ADDR_WIDTH-1:0]   iCpuAddr;
    logic [DATA_WIDTH-1:0]   iCpuData;
    logic                    iFillStart;
    logic                    iFillAbort;
    logic [GRID_BITS-1:0]    iFillX0;
    logic [GRID_BITS-1:0]    iFillY0;
    logic [GRID_BITS-1:0]    iFillX1;
    logic [GRID_BITS-1:0]    iFillY1;
    logic [DATA_WIDTH-1:0]   iFillColor;
    logic                    oWriteEnable;
    logic [ADDR_WIDTH-1:0]   oWriteAddress;
    logic [DATA_WIDTH-1:0]   oDataIn;
    logic                    oBusy;
    logic                    oDone;
    logic                    oError;
    logic [ADDR_WIDTH:0]     oFillCount;

    modport master (
        output iCpuWrite, iCpuAddr, iCpuData,
        output iFillStart, iFillAbort, iFillX0, iFillY0, iFillX1, iFillY1, iFillColor,
        input  oWriteEnable, oWriteAddress, oDataIn, oBusy, oDone, oError, oFillCount
    );

    modport slave (
        input  iCpuWrite, iCpuAddr, iCpuData,
        input  iFillStart, iFillAbort, iFillX0, iFillY0, iFillX1, iFillY1, iFillColor,
        output oWriteEnable, oWriteAddress, oDataIn, oBusy, oDone, oError, oFillCount
    );
endinterface

// File: rtl/vram_fill_arbiter.sv
// Shares the single video-memory write port between CPU WVM writes and a
// rectangle-fill engine; CPU writes always win and stall the fill cursor.
module vram_fill_arbiter #(
    parameter int DATA_WIDTH = 3,
    parameter int GRID_BITS  = 5,
    parameter int ADDR_WIDTH = 2 * GRID_BITS
) (
    input  logic                 Clock,
    input  logic                 Reset,
    vram_fill_arbiter_if.slave   bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } fillState_e;

    fillState_e              state, nextState;

    logic [GRID_BITS-1:0]    x0, y0, x1, y1;
    logic [GRID_BITS-1:0]    nextX0, nextY0, nextX1, nextY1;
    logic [DATA_WIDTH-1:0]   color, nextColor;
    logic [GRID_BITS-1:0]    curX, curY, nextCurX, nextCurY;

    logic                    wrEn, nextWrEn;
    logic [ADDR_WIDTH-1:0]   wrAddr, nextWrAddr;
    logic [DATA_WIDTH-1:0]   wrData, nextWrData;
    logic [CNT_W-1:0]        fillCount, nextFillCount;
    logic                    error, nextError;

    logic                    lastCell;
    logic                    badRect;

    assign lastCell = (curX == x1) && (curY == y1);
    assign badRect  = (bus.iFillX0 > bus.iFillX1) || (bus.iFillY0 > bus.iFillY1);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= StIdle;
            x0        <= '0;
            y0        <= '0;
            x1        <= '0;
            y1        <= '0;
            color     <= '0;
            curX      <= '0;
            curY      <= '0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            fillCount <= '0;
            error     <= 1'b0;
        end else begin
            state     <= nextState;
            x0        <= nextX0;
            y0        <= nextY0;
            x1        <= nextX1;
            y1        <= nextY1;
            color     <= nextColor;
            curX      <= nextCurX;
            curY      <= nextCurY;
            wrEn      <= nextWrEn;
            wrAddr    <= nextWrAddr;
            wrData    <= nextWrData;
            fillCount <= nextFillCount;
            error     <= nextError;
        end
    end

    always_comb begin
        nextState     = state;
        nextX0        = x0;
        nextY0        = y0;
        nextX1        = x1;
        nextY1        = y1;
        nextColor     = color;
        nextCurX      = curX;
        nextCurY      = curY;
        nextWrEn      = 1'b0;
        nextWrAddr    = wrAddr;
        nextWrData    = wrData;
        nextFillCount = fillCount;
        nextError     = error;

        // CPU owns the port this edge; any fill write simply holds the cursor.
        if (bus.iCpuWrite) begin
            nextWrEn   = 1'b1;
            nextWrAddr = bus.iCpuAddr;
            nextWrData = bus.iCpuData;
        end

        case (state)
            StIdle: begin
                if (bus.iFillStart) begin
                    nextX0        = bus.iFillX0;
                    nextY0        = bus.iFillY0;
                    nextX1        = bus.iFillX1;
                    nextY1        = bus.iFillY1;
                    nextColor     = bus.iFillColor;
                    nextFillCount = '0;
                    if (badRect) begin
                        nextError = 1'b1;
                        nextState = StDone;
                    end else begin
                        nextError = 1'b0;
                        nextCurX  = bus.iFillX0;
                        nextCurY  = bus.iFillY0;
                        nextState = StFill;
                    end
                end
            end

            StFill: begin
                if (bus.iFillAbort) begin
                    nextState = StIdle;
                end else if (!bus.iCpuWrite) begin
                    nextWrEn      = 1'b1;
                    nextWrAddr    = {curY, curX};
                    nextWrData    = color;
                    nextFillCount = fillCount + CNT_W'(1);
                    // Cursor is frozen on the final cell so row 31 never wraps.
                    if (lastCell) begin
                        nextState = StDone;
                    end else if (curX == x1) begin
                        nextCurX = x0;
                        nextCurY = curY + GRID_BITS'(1);
                    end else begin
                        nextCurX = curX + GRID_BITS'(1);
                    end
                end
            end

            StDone: begin
                nextState = StIdle;
            end

            default: begin
                nextState = StIdle;
            end
        endcase
    end

    assign bus.oWriteEnable  = wrEn;
    assign bus.oWriteAddress = wrAddr;
    assign bus.oDataIn       = wrData;
    assign bus.oBusy         = (state == StFill) || (state == StDone);
    assign bus.oDone         = (state == StDone);
    assign bus.oError        = error;
    assign bus.oFillCount    = fillCount;
endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Directed bench for vram_fill_arbiter: CPU priority, fill ordering, error,
// abort and reset behaviour, checked with immediate assertions.
module tb_vram_fill_arbiter;
    logic Clock;
    logic Reset;
    int   errors;
    int   checks;

    vram_fill_arbiter_if #(.DATA_WIDTH(3), .GRID_BITS(5), .ADDR_WIDTH(10)) bus ();

    vram_fill_arbiter #(.DATA_WIDTH(3), .GRID_BITS(5), .ADDR_WIDTH(10)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later, inputs change at the same point.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clearInputs();
        bus.iCpuWrite  = 1'b0;
        bus.iCpuAddr   = '0;
        bus.iCpuData   = '0;
        bus.iFillStart = 1'b0;
        bus.iFillAbort = 1'b0;
    endtask

    task automatic startFill(input int fx0, input int fy0, input int fx1, input int fy1, input int col);
        bus.iFillX0    = 5'(fx0);
        bus.iFillY0    = 5'(fy0);
        bus.iFillX1    = 5'(fx1);
        bus.iFillY1    = 5'(fy1);
        bus.iFillColor = 3'(col);
        bus.iFillStart = 1'b1;
        step();
        bus.iFillStart = 1'b0;
    endtask

    task automatic checkWrite(input string tag, input int addr, input int data);
        check({tag, "_we"}, int'(bus.oWriteEnable), 1);
        check({tag, "_addr"}, int'(bus.oWriteAddress), addr);
        check({tag, "_data"}, int'(bus.oDataIn), data);
    endtask

    initial begin
        int seq2 [6];
        int seq3 [6];
        int writes;
        int badAddr;
        int badData;
        int lastAddr;
        int doneSeen;
        int extra;

        errors = 0;
        checks = 0;
        seq2 = '{98, 99, 100, 130, 131, 132};
        seq3 = '{99, 100, 130, 131, 132, 0};
        Reset = 1'b0;
        clearInputs();
        bus.iFillX0 = '0; bus.iFillY0 = '0; bus.iFillX1 = '0; bus.iFillY1 = '0;
        bus.iFillColor = '0;

        // 1: reset and first CPU write
        step(); step();
        check("rst_we", int'(bus.oWriteEnable), 0);
        check("rst_busy", int'(bus.oBusy), 0);
        check("rst_done", int'(bus.oDone), 0);
        check("rst_err", int'(bus.oError), 0);
        check("rst_cnt", int'(bus.oFillCount), 0);
        Reset = 1'b1;
        step(); step();
        check("idle_we", int'(bus.oWriteEnable), 0);
        check("idle_busy", int'(bus.oBusy), 0);
        bus.iCpuWrite = 1'b1; bus.iCpuAddr = 10'd5; bus.iCpuData = 3'd2;
        step();
        clearInputs();
        checkWrite("cpu1", 5, 2);
        step();
        check("cpu1_off", int'(bus.oWriteEnable), 0);

        // 2: plain fill (2,3)-(4,4)
        startFill(2, 3, 4, 4, 5);
        check("f2_busy0", int'(bus.oBusy), 1);
        check("f2_we0", int'(bus.oWriteEnable), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            checkWrite($sformatf("f2_w%0d", i), seq2[i], 5);
            check($sformatf("f2_cnt%0d", i), int'(bus.oFillCount), i + 1);
            check($sformatf("f2_done%0d", i), int'(bus.oDone), (i == 5) ? 1 : 0);
        end
        step();
        check("f2_busy_end", int'(bus.oBusy), 0);
        check("f2_we_end", int'(bus.oWriteEnable), 0);
        check("f2_cnt_end", int'(bus.oFillCount), 6);

        // 3: CPU write steals the slot of address 99
        startFill(2, 3, 4, 4, 5);
        step();
        checkWrite("f3_w0", 98, 5);
        bus.iCpuWrite = 1'b1; bus.iCpuAddr = 10'd500; bus.iCpuData = 3'd1;
        step();
        clearInputs();
        checkWrite("f3_cpu", 500, 1);
        check("f3_cnt_cpu", int'(bus.oFillCount), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkWrite($sformatf("f3_w%0d", i + 1), seq3[i], 5);
            check($sformatf("f3_done%0d", i + 1), int'(bus.oDone), (i == 4) ? 1 : 0);
        end
        check("f3_cnt", int'(bus.oFillCount), 6);
        step();
        check("f3_busy_end", int'(bus.oBusy), 0);

        // 4: rejected command, then a valid single-cell fill clears the error
        startFill(7, 0, 3, 0, 4);
        check("f4_we", int'(bus.oWriteEnable), 0);
        check("f4_err", int'(bus.oError), 1);
        check("f4_done", int'(bus.oDone), 1);
        check("f4_cnt", int'(bus.oFillCount), 0);
        step();
        check("f4_done_off", int'(bus.oDone), 0);
        check("f4_we2", int'(bus.oWriteEnable), 0);
        check("f4_err_hold", int'(bus.oError), 1);
        check("f4_busy_off", int'(bus.oBusy), 0);
        startFill(9, 9, 9, 9, 3);
        check("f4_err_clr", int'(bus.oError), 0);
        step();
        checkWrite("f4_single", 9 * 32 + 9, 3);
        check("f4_single_done", int'(bus.oDone), 1);
        check("f4_single_cnt", int'(bus.oFillCount), 1);
        step();
        check("f4_single_idle", int'(bus.oBusy), 0);

        // 5: full screen with a stray restart mid-fill
        startFill(0, 0, 31, 31, 0);
        writes = 0; badAddr = 0; badData = 0; lastAddr = -1; doneSeen = 0;
        for (int c = 0; c < 1100 && doneSeen == 0; c++) begin
            if (c == 400) begin
                bus.iFillX0 = 5'd1; bus.iFillY0 = 5'd1;
                bus.iFillX1 = 5'd2; bus.iFillY1 = 5'd2;
                bus.iFillColor = 3'd7;
                bus.iFillStart = 1'b1;
            end else begin
                bus.iFillStart = 1'b0;
            end
            step();
            if (bus.oWriteEnable) begin
                if (int'(bus.oWriteAddress) != writes) badAddr++;
                if (bus.oDataIn != 3'd0) badData++;
                lastAddr = int'(bus.oWriteAddress);
                writes++;
            end
            if (bus.oDone) doneSeen = 1;
        end
        bus.iFillStart = 1'b0;
        check("f5_done_seen", doneSeen, 1);
        check("f5_writes", writes, 1024);
        check("f5_bad_addr", badAddr, 0);
        check("f5_bad_data", badData, 0);
        check("f5_last_addr", lastAddr, 1023);
        check("f5_cnt", int'(bus.oFillCount), 1024);
        check("f5_err", int'(bus.oError), 0);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.oWriteEnable) extra++;
        end
        check("f5_no_extra", extra, 0);
        check("f5_busy_end", int'(bus.oBusy), 0);

        // 6a: abort after 10 writes, with a CPU write on the abort edge
        startFill(0, 0, 31, 31, 6);
        for (int i = 0; i < 10; i++) step();
        checkWrite("f6_w9", 9, 6);
        check("f6_cnt10", int'(bus.oFillCount), 10);
        bus.iFillAbort = 1'b1;
        bus.iCpuWrite = 1'b1; bus.iCpuAddr = 10'd777; bus.iCpuData = 3'd4;
        step();
        clearInputs();
        checkWrite("f6_abort_cpu", 777, 4);
        check("f6_abort_busy", int'(bus.oBusy), 0);
        check("f6_abort_done", int'(bus.oDone), 0);
        check("f6_abort_cnt", int'(bus.oFillCount), 10);
        extra = 0; doneSeen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.oWriteEnable) extra++;
            if (bus.oDone) doneSeen = 1;
        end
        check("f6_abort_nowr", extra, 0);
        check("f6_abort_nodone", doneSeen, 0);
        check("f6_abort_cnt2", int'(bus.oFillCount), 10);

        // 6b: asynchronous reset mid-fill
        startFill(0, 0, 31, 31, 2);
        for (int i = 0; i < 5; i++) step();
        check("f6r_we_pre", int'(bus.oWriteEnable), 1);
        #2;
        Reset = 1'b0;
        #1;
        check("f6r_we", int'(bus.oWriteEnable), 0);
        check("f6r_busy", int'(bus.oBusy), 0);
        check("f6r_cnt", int'(bus.oFillCount), 0);
        step(); step();
        check("f6r_we_hold", int'(bus.oWriteEnable), 0);
        Reset = 1'b1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.oWriteEnable || bus.oBusy) extra++;
        end
        check("f6r_no_resume", extra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vram_fill_arbiter.md
Name: vram_fill_arbiter

Overview:
Write-port controller for the 32x32-cell, 3-bit video memory.
- Shares the single memory write port between two requesters: CPU writes issued by the WVM instruction, and a hardware rectangle-fill engine.
- The fill engine lets the program clear or paint a rectangle with one command instead of a WVM loop.
- Sits between the MiniAlu instruction decode and the video memory's write address, write data and write-enable inputs.

Parameters:
DATA_WIDTH, 3, color bits per cell
GRID_BITS, 5, bits per coordinate (32 cells per axis)
ADDR_WIDTH, 10, video memory address width; always 2*GRID_BITS

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (asserted when 0)
iCpuWrite  in  1  CPU write request, single-cycle, no backpressure
iCpuAddr  in  10  CPU write address
iCpuData  in  3  CPU write color
iFillStart  in  1  fill command strobe
iFillAbort  in  1  cancel the running fill
iFillX0  in  5  left column
iFillY0  in  5  top row
iFillX1  in  5  right column (inclusive)
iFillY1  in  5  bottom row (inclusive)
iFillColor  in  3  fill color
oWriteEnable  out  1  video memory write enable
oWriteAddress  out  10  video memory write address, {row,col}
oDataIn  out  3  video memory write data
oBusy  out  1  high in FILL and DONE
oDone  out  1  one-cycle pulse when a fill ends (normal or error)
oError  out  1  high after a rejected command, until the next accepted start
oFillCount  out  11  cells written by the current or last fill

Behaviour:
- Reset (Reset=0), asynchronous: state IDLE; every output 0; latched coordinates and color 0.
- States are IDLE, FILL and DONE.
- Write port outputs are registered. Any write decided in cycle N appears on the port in cycle N+1, with oWriteEnable high for exactly that one cycle.
- Address rule: address = {y[4:0], x[4:0]} = y*32 + x.
- CPU has absolute priority in every state. If iCpuWrite=1 at an edge, the port carries iCpuAddr/iCpuData in the next cycle. Any fill write due that cycle is deferred; no cell is skipped or duplicated.
- IDLE:
  - iFillStart=1 latches X0, Y0, X1, Y1 and the color, clears oFillCount and clears oError.
  - If X0>X1 or Y0>Y1: set oError=1 and go to DONE. No fill writes are issued.
  - Otherwise: cursor = (X0,Y0), go to FILL.
- FILL:
  - Each edge without iCpuWrite issues a fill write at the cursor and increments oFillCount.
  - The cursor advances column-first: if x==X1 then x=X0 and y=y+1, else x=x+1.
  - The write of cell (X1,Y1) moves the FSM to DONE.
- DONE: lasts exactly one cycle with oDone=1, then returns to IDLE. The oDone cycle coincides with the last fill write appearing on the port.
- iFillStart is ignored in FILL and DONE, with no effect on the latched command.
- iFillAbort:
  - In FILL: go to IDLE on the next edge, issue no further fill writes, do not pulse oDone. oFillCount keeps the partial count.
  - Abort has priority over a same-edge fill write; a simultaneous CPU write is still honored.
  - Ignored in IDLE and DONE.
- Single-cell fill (X0=X1, Y0=Y1): one write, then DONE.
- Full screen (0,0)-(31,31): 1024 writes, oFillCount=1024. The cursor never wraps past row 31.
- No write is ever issued while Reset=0. After release, the block starts in IDLE with no pending fill.

Test Plan:
1. Hold Reset=0, then release. All outputs stay 0 until a CPU or fill request arrives; a CPU write of addr 5, data 2 appears on the port the next cycle.
2. Fill (2,3)-(4,4), color 5, no CPU traffic:
   - Port shows addresses 98, 99, 100, 130, 131, 132 in six consecutive cycles, data 5.
   - oDone pulses in the cycle address 132 is on the port; oFillCount=6; oBusy low the next cycle.
3. Same fill with iCpuWrite (addr 500, data 1) on the edge that would issue address 99:
   - Port sequence is 98, 500/1, 99, 100, 130, 131, 132 (seven cycles).
   - oFillCount=6.
4. Start with X0=7, X1=3:
   - No writes issued; oError=1; one oDone pulse; oFillCount=0.
   - A following valid start clears oError.
5. Fill (0,0)-(31,31), color 0, with iFillStart re-pulsed mid-fill:
   - Exactly 1024 writes; first address 0, last address 1023; oFillCount=1024.
   - The second start has no effect.
6. Mid-fill events:
   - iFillAbort after 10 writes: writes stop, no oDone, oFillCount=10.
   - Separate run, Reset=0 mid-fill: oWriteEnable and oBusy drop immediately, and no writes occur after Reset returns to 1.
